sample_loader: RTL and testbench

//  Upstream feeder for the 64x8 sample memory of the linear-regression datapath.

---
 rtl/sample_loader.sv | 121 ++++++++++++
 tb/tb_sample_loader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_loader.sv
// Purpose: loads interleaved (x,y) byte pairs from a valid/ready stream into the 64x8 sample memory.
// Latency: a byte accepted at edge k is driven on the memory port in cycle k+1; done pulses 2 cycles after the last accept.
// Backpressure: in_ready depends on FSM state only; in_valid=0 stalls the load indefinitely.
// Ports: clk/rst_n; start/n_pairs/abort control; in_valid/in_data/in_ready stream;
//        mem_data/mem_addr/mem_wr memory write port; busy/done/err/count status.
module sample_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 6,
    parameter int N_MAX  = 32,
    parameter int Y_BASE = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] n_pairs,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] mem_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_X,
        S_LOAD_Y,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] Y_BASE_A = ADDR_W'(Y_BASE);
    localparam logic [ADDR_W:0]   N_MAX_W  = (ADDR_W+1)'(N_MAX);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] n_lat;
    logic              n_bad;

    // One extra bit so N_MAX itself is representable in the comparison.
    assign n_bad    = (n_pairs == '0) || ({1'b0, n_pairs} > N_MAX_W);
    assign in_ready = (state == S_LOAD_X) || (state == S_LOAD_Y);
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            idx      <= '0;
            n_lat    <= '0;
            mem_wr   <= 1'b0;
            mem_addr <= '0;
            mem_data <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
            count    <= '0;
        end else begin
            // Pulse outputs default low; address/data hold their last value.
            mem_wr <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (n_bad) begin
                            err <= 1'b1;
                        end else begin
                            n_lat <= n_pairs;
                            idx   <= '0;
                            count <= '0;
                            state <= S_LOAD_X;
                        end
                    end
                end
                S_LOAD_X: begin
                    // Abort wins over a byte arriving on the same edge: it is dropped.
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (in_valid) begin
                        mem_wr   <= 1'b1;
                        mem_addr <= idx;
                        mem_data <= in_data;
                        state    <= S_LOAD_Y;
                    end
                end
                S_LOAD_Y: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (in_valid) begin
                        mem_wr   <= 1'b1;
                        mem_addr <= Y_BASE_A + idx;
                        mem_data <= in_data;
                        count    <= idx + 1'b1;
                        if (idx == n_lat - 1'b1) begin
                            state <= S_FLUSH;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= S_LOAD_X;
                        end
                    end
                end
                S_FLUSH: begin
                    // Final y write is on the memory port now; done lands the cycle after.
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_loader.sv
module tb_sample_loader;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [5:0] n_pairs;
    logic       abort;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [7:0] mem_data;
    logic [5:0] mem_addr;
    logic       mem_wr;
    logic       busy;
    logic       done;
    logic       err;
    logic [5:0] count;

    typedef struct packed {
        logic [5:0] addr;
        logic [7:0] data;
    } wr_t;

    int  n_cmp = 0;
    int  n_bad = 0;
    int  cyc = 0;
    int  done_cnt = 0;
    int  err_cnt = 0;
    int  done_cyc = 0;
    int  last_acc_cyc = 0;
    wr_t wq[$];

    sample_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .n_pairs  (n_pairs),
        .abort    (abort),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .mem_data (mem_data),
        .mem_addr (mem_addr),
        .mem_wr   (mem_wr),
        .busy     (busy),
        .done     (done),
        .err      (err),
        .count    (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observer: everything sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rst_n) begin
            if (mem_wr) wq.push_back('{addr: mem_addr, data: mem_data});
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (err) err_cnt <= err_cnt + 1;
            if (in_valid && in_ready) last_acc_cyc <= cyc;
        end
    end

    task automatic do_start(input int n);
        @(negedge clk);
        start   = 1'b1;
        n_pairs = 6'(n);
        @(negedge clk);
        start   = 1'b0;
    endtask

    // mode 0: valid held high, 1: toggling, 2: random gaps
    task automatic drive_bytes(input logic [7:0] b[$], input int mode, output bit ready_ok, output bit timed_out);
        int i = 0;
        int c = 0;
        logic v;
        ready_ok  = 1'b1;
        timed_out = 1'b0;
        while (i < b.size() && c < 4000) begin
            @(negedge clk);
            c++;
            if (in_ready !== 1'b1) ready_ok = 1'b0;
            v = (mode == 0) ? 1'b1 : (mode == 1) ? ((c % 2) == 1) : 1'($urandom_range(0, 1));
            in_valid = v;
            in_data  = b[i];
            if (v && in_ready) i++;
        end
        if (i < b.size()) timed_out = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Expected memory image of the first nb stream bytes: byte j belongs to pair j/2,
    // even bytes go to the x region, odd bytes to the y region.
    task automatic check_writes(input logic [7:0] b[$], input int nb, input string name);
        logic [5:0] ea;
        n_cmp++;
        if (wq.size() !== nb) begin
            n_bad++;
            $display("FAIL %s write_count got=%0d want=%0d", name, wq.size(), nb);
        end
        for (int j = 0; j < nb && j < wq.size(); j++) begin
            ea = (j % 2 == 1) ? 6'((32 + j / 2) % 64) : 6'(j / 2);
            n_cmp++;
            if (wq[j].addr !== ea || wq[j].data !== b[j]) begin
                n_bad++;
                $display("FAIL %s write[%0d] got=(%0d,%0d) want=(%0d,%0d)",
                         name, j, wq[j].addr, wq[j].data, ea, b[j]);
            end
        end
    endtask

    task automatic run_load(input int n, input int mode, input logic [7:0] fixed[$], input string name);
        logic [7:0] b[$];
        bit ready_ok, to;
        b = fixed;
        if (b.size() == 0)
            for (int j = 0; j < 2 * n; j++) b.push_back(8'($urandom));
        wq.delete();
        done_cnt = 0;
        do_start(n);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL %s busy_after_start got=%b want=1", name, busy);
        end
        drive_bytes(b, mode, ready_ok, to);
        n_cmp++;
        if (to) begin
            n_bad++;
            $display("FAIL %s stream_timeout got=1 want=0", name);
        end
        n_cmp++;
        if (!ready_ok) begin
            n_bad++;
            $display("FAIL %s in_ready_dropped got=0 want=1", name);
        end
        repeat (4) @(negedge clk);
        check_writes(b, 2 * n, name);
        n_cmp++;
        if (done_cnt !== 1) begin
            n_bad++;
            $display("FAIL %s done_pulses got=%0d want=1", name, done_cnt);
        end
        n_cmp++;
        if (count !== 6'(n)) begin
            n_bad++;
            $display("FAIL %s count got=%0d want=%0d", name, count, n);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL %s busy_at_end got=%b want=0", name, busy);
        end
        if (mode == 0) begin
            n_cmp++;
            if (done_cyc - last_acc_cyc !== 2) begin
                n_bad++;
                $display("FAIL %s done_latency got=%0d want=2", name, done_cyc - last_acc_cyc);
            end
        end
    endtask

    task automatic check_outputs_zero(input string name);
        n_cmp++;
        if ({in_ready, mem_wr, done, err, busy} !== 5'b0 || count !== 6'd0 ||
            mem_addr !== 6'd0 || mem_data !== 8'd0) begin
            n_bad++;
            $display("FAIL %s outputs rdy=%b wr=%b done=%b err=%b busy=%b cnt=%0d addr=%0d data=%0d want all 0",
                     name, in_ready, mem_wr, done, err, busy, count, mem_addr, mem_data);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0; n_pairs = '0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
        #12;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs_zero("after_reset");
    endtask

    task automatic test_basic();
        logic [7:0] b[$];
        b = '{8'd10, 8'd20, 8'd11, 8'd21, 8'd12, 8'd22};
        run_load(3, 0, b, "basic");
    endtask

    task automatic test_toggle();
        logic [7:0] e[$];
        run_load(2, 1, e, "toggle");
    endtask

    task automatic test_err();
        err_cnt = 0;
        wq.delete();
        do_start(0);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL err_zero busy got=%b want=0", busy);
        end
        do_start(33);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++;
            $display("FAIL err_33 busy got=%b want=0", busy);
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (err_cnt !== 2) begin
            n_bad++;
            $display("FAIL err_pulses got=%0d want=2", err_cnt);
        end
        n_cmp++;
        if (wq.size() !== 0) begin
            n_bad++;
            $display("FAIL err_writes got=%0d want=0", wq.size());
        end
    endtask

    task automatic test_full();
        logic [7:0] e[$];
        run_load(32, 0, e, "full");
    endtask

    task automatic test_abort();
        logic [7:0] b[$];
        logic [7:0] head[$];
        bit ready_ok, to;
        for (int j = 0; j < 6; j++) b.push_back(8'($urandom));
        head = b[0:2];
        wq.delete();
        done_cnt = 0;
        do_start(3);
        drive_bytes(head, 0, ready_ok, to);
        // Now in LOAD_Y waiting for y1: present it together with abort.
        in_valid = 1'b1;
        in_data  = b[3];
        abort    = 1'b1;
        @(negedge clk);
        abort    = 1'b0;
        in_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b0 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_idle busy=%b rdy=%b want 0,0", busy, in_ready);
        end
        repeat (4) @(negedge clk);
        check_writes(b, 3, "abort");
        n_cmp++;
        if (done_cnt !== 0) begin
            n_bad++;
            $display("FAIL abort_done got=%0d want=0", done_cnt);
        end
        n_cmp++;
        if (count !== 6'd1) begin
            n_bad++;
            $display("FAIL abort_count got=%0d want=1", count);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] b[$];
        logic [7:0] e[$];
        bit ready_ok, to;
        for (int j = 0; j < 3; j++) b.push_back(8'($urandom));
        do_start(4);
        drive_bytes(b, 0, ready_ok, to);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        run_load(1, 0, e, "after_reset_mid");
    endtask

    task automatic test_random();
        logic [7:0] e[$];
        for (int k = 0; k < 4; k++)
            run_load(int'($urandom_range(1, 32)), 2, e, $sformatf("random%0d", k));
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_err();
        test_full();
        test_abort();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
